// File: rtl/ps2_pkg.sv
// PS/2 receiver shared types: frame FSM encoding, prefix scan codes, event entry layout.
// Event entry = {ext, brk, code[7:0]}.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  localparam int ENTRY_W  = 10;
  localparam int CODE_LSB = 0;
  localparam int CODE_W   = 8;
  localparam int BRK_BIT  = 8;
  localparam int EXT_BIT  = 9;

endpackage

// File: rtl/ps2_fifo.sv
// First-word-fall-through FIFO: head visible combinationally, write-to-visible latency 1 cycle.
// Push when full without pop is dropped; pop when empty is ignored.
module ps2_fifo #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_hold;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign count     = r_count;
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  // When drained, keep presenting the last head instead of stale storage.
  assign dout      = empty ? r_hold : r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hold   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (!empty)    r_hold   <= r_mem[r_rd_ptr];
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: line filter, 11-bit deframer, E0/F0 prefix folding, event FIFO.
// Byte enters FIFO one cycle after the stop-bit strobe; full FIFO drops events and pulses ovf_o.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter  int FILT_LEN    = 8,
  parameter  int TIMEOUT_CYC = 20000,
  parameter  int FIFO_DEPTH  = 8,
  localparam int AW          = $clog2(FIFO_DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        rx_en,
  input  logic        rd_i,
  output logic [7:0]  code_o,
  output logic        brk_o,
  output logic        ext_o,
  output logic        empty_o,
  output logic        full_o,
  output logic [AW:0] count_o,
  output logic        err_par_o,
  output logic        err_frm_o,
  output logic        ovf_o
);

  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]         r_clk_s;
  logic [1:0]         r_dat_s;
  logic               r_filt_clk;
  logic               r_filt_prev;
  logic [FCW-1:0]     r_filt_cnt;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic               r_par;
  logic [TW-1:0]      r_tmo_cnt;
  logic [7:0]         r_byte;
  logic               r_byte_vld;
  logic               r_err_par;
  logic               r_err_frm;
  logic               r_ovf;
  logic               r_ext;
  logic               r_brk;
  logic               w_strobe;
  logic               w_data;
  logic               w_tmo;
  logic               w_byte_vld;
  logic               w_err_par;
  logic               w_err_frm;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_din;
  logic [ENTRY_W-1:0] w_head;

  assign w_strobe = r_filt_prev & ~r_filt_clk;
  assign w_data   = r_dat_s[1];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_clk_s     <= 2'b11;
      r_dat_s     <= 2'b11;
      r_filt_clk  <= 1'b1;
      r_filt_prev <= 1'b1;
      r_filt_cnt  <= '0;
    end else begin
      r_clk_s     <= {r_clk_s[0], ps2_clk};
      r_dat_s     <= {r_dat_s[0], ps2_data};
      r_filt_prev <= r_filt_clk;
      // Count consecutive samples that disagree with the filtered level.
      if (r_clk_s[1] != r_filt_clk) begin
        if (r_filt_cnt == FCW'(FILT_LEN - 1)) begin
          r_filt_clk <= ~r_filt_clk;
          r_filt_cnt <= '0;
        end else begin
          r_filt_cnt <= r_filt_cnt + 1'b1;
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  assign w_tmo = (r_state != ST_IDLE) && !w_strobe && (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_byte_vld  = 1'b0;
    w_err_par   = 1'b0;
    w_err_frm   = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_strobe && rx_en && !w_data) w_state_nxt = ST_DATA;
      ST_DATA:   if (w_strobe && r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
      ST_PARITY: if (w_strobe) w_state_nxt = ST_STOP;
      ST_STOP: begin
        if (w_strobe) begin
          w_state_nxt = ST_IDLE;
          if (!(^{r_shift, r_par})) w_err_par  = 1'b1;
          else if (!w_data)         w_err_frm  = 1'b1;
          else                      w_byte_vld = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_tmo) begin
      w_state_nxt = ST_IDLE;
      w_err_frm   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tmo_cnt  <= '0;
      r_byte     <= '0;
      r_byte_vld <= 1'b0;
      r_err_par  <= 1'b0;
      r_err_frm  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE || w_strobe) r_tmo_cnt <= '0;
      else                                r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_strobe) begin
        case (r_state)
          ST_IDLE:   r_bit_cnt <= '0;
          ST_DATA: begin
            r_shift   <= {w_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          ST_PARITY: r_par <= w_data;
          default:   r_par <= r_par;
        endcase
      end
      if (w_byte_vld) r_byte <= r_shift;
      r_byte_vld <= w_byte_vld;
      r_err_par  <= w_err_par;
      r_err_frm  <= w_err_frm;
    end
  end

  assign w_push = r_byte_vld && (r_byte != SC_EXT) && (r_byte != SC_BRK);
  assign w_din  = {r_ext, r_brk, r_byte};

  // Prefix flags apply to the next non-prefix byte; any frame error discards them.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_push & w_full & ~rd_i;
      if (r_err_par || r_err_frm) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (r_byte_vld) begin
        if (r_byte == SC_EXT)      r_ext <= 1'b1;
        else if (r_byte == SC_BRK) r_brk <= 1'b1;
        else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
    end
  end

  ps2_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (w_push),
    .pop   (rd_i),
    .din   (w_din),
    .dout  (w_head),
    .empty (w_empty),
    .full  (w_full),
    .count (count_o)
  );

  assign code_o    = w_head[CODE_LSB +: CODE_W];
  assign brk_o     = w_head[BRK_BIT];
  assign ext_o     = w_head[EXT_BIT];
  assign empty_o   = w_empty;
  assign full_o    = w_full;
  assign err_par_o = r_err_par;
  assign err_frm_o = r_err_frm;
  assign ovf_o     = r_ovf;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: bit-banged PS/2 frames, expected events queued on send, compared on read.
module tb_ps2_rx_fifo;
  localparam int HALF  = 20;
  localparam int TMO   = 1000;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n, ps2_clk, ps2_data, rx_en, rd;
  logic [7:0] code_o;
  logic       brk_o, ext_o, empty_o, full_o, err_par_o, err_frm_o, ovf_o;
  logic [3:0] count_o;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.FILT_LEN(8), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rx_en(rx_en),
    .rd_i(rd), .code_o(code_o), .brk_o(brk_o), .ext_o(ext_o), .empty_o(empty_o),
    .full_o(full_o), .count_o(count_o), .err_par_o(err_par_o), .err_frm_o(err_frm_o),
    .ovf_o(ovf_o)
  );

  int errors = 0;
  int checks = 0;
  logic [9:0] sbq[$];
  logic ext_f = 1'b0, brk_f = 1'b0;

  int n_par = 0, n_frm = 0, n_ovf = 0, n_wide = 0;
  logic p_par = 1'b0, p_frm = 1'b0, p_ovf = 1'b0;

  always @(negedge clk) begin
    if ((err_par_o && p_par) || (err_frm_o && p_frm) || (ovf_o && p_ovf)) n_wide++;
    if (err_par_o === 1'b1) n_par++;
    if (err_frm_o === 1'b1) n_frm++;
    if (ovf_o === 1'b1)     n_ovf++;
    p_par = err_par_o; p_frm = err_frm_o; p_ovf = ovf_o;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (observed timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par, input logic stop);
    return {stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      ps2_data = f[i];
      repeat (HALF/2) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF/2) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0)      ext_f = 1'b1;
    else if (b == 8'hF0) brk_f = 1'b1;
    else begin
      if (sbq.size() < DEPTH) sbq.push_back({ext_f, brk_f, b});
      ext_f = 1'b0;
      brk_f = 1'b0;
    end
  endtask

  task automatic good(input logic [7:0] b);
    send_bits(frame(b, 1'b0, 1'b1), 0, 11);
    model_byte(b);
  endtask

  task automatic bad(input logic [7:0] b, input logic bad_par, input logic stop);
    send_bits(frame(b, bad_par, stop), 0, 11);
    ext_f = 1'b0;
    brk_f = 1'b0;
  endtask

  task automatic read_check(input string tag);
    int t;
    logic [9:0] exp;
    t = 0;
    while (empty_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_avail"}, 32'(empty_o), 32'd0);
    exp = (sbq.size() > 0) ? sbq.pop_front() : 10'h3FF;
    chk(tag, 32'({ext_o, brk_o, code_o}), 32'(exp));
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  initial begin
    int snap_par, snap_frm, snap_ovf;
    logic [10:0] f;
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rx_en = 1'b1; rd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_head", 32'({ext_o, brk_o, code_o}), 32'd0);
    chk("rst_pulses", 32'({err_par_o, err_frm_o, ovf_o}), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single plain key
    good(8'h1C);
    chk("t1_count", 32'(count_o), 32'd1);
    read_check("t1_head");
    chk("t1_empty_after_rd", 32'(empty_o), 32'd1);

    // Prefix folding
    good(8'hE0); good(8'hF0); good(8'h74); good(8'h1C);
    chk("t2_count", 32'(count_o), 32'd2);
    read_check("t2_ext_brk_74");
    read_check("t2_plain_1c");
    chk("t2_empty", 32'(empty_o), 32'd1);

    // Parity and stop errors
    snap_par = n_par; snap_frm = n_frm;
    bad(8'h1C, 1'b1, 1'b1);
    chk("t3_par_pulse", 32'(n_par - snap_par), 32'd1);
    chk("t3_par_nofrm", 32'(n_frm - snap_frm), 32'd0);
    chk("t3_par_count", 32'(count_o), 32'd0);
    snap_par = n_par;
    bad(8'h1C, 1'b0, 1'b0);
    chk("t3_frm_pulse", 32'(n_frm - snap_frm), 32'd1);
    chk("t3_frm_nopar", 32'(n_par - snap_par), 32'd0);
    chk("t3_frm_count", 32'(count_o), 32'd0);
    good(8'hE0);
    bad(8'h55, 1'b1, 1'b1);
    good(8'h1C);
    read_check("t3_err_clears_ext");

    // Timeout mid-frame
    snap_frm = n_frm;
    send_bits(frame(8'h5B, 1'b0, 1'b1), 0, 6);
    repeat (TMO + 100) @(negedge clk);
    chk("t4_tmo_pulse", 32'(n_frm - snap_frm), 32'd1);
    chk("t4_tmo_count", 32'(count_o), 32'd0);
    good(8'h29);
    read_check("t4_after_tmo_29");

    // Fill, overflow, simultaneous push and pop while full
    for (int b = 1; b <= 8; b++) good(8'(b));
    chk("t5_full", 32'(full_o), 32'd1);
    chk("t5_count8", 32'(count_o), 32'd8);
    snap_ovf = n_ovf;
    good(8'h09);
    chk("t5_ovf_pulse", 32'(n_ovf - snap_ovf), 32'd1);
    chk("t5_count_after_ovf", 32'(count_o), 32'd8);
    snap_ovf = n_ovf;
    f = frame(8'h0A, 1'b0, 1'b1);
    send_bits(f, 0, 10);
    ps2_data = f[10];
    repeat (HALF/2) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (11) @(negedge clk);
    chk("t5_pop_head", 32'({ext_o, brk_o, code_o}), 32'(sbq.pop_front()));
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    repeat (HALF - 12) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF/2) @(negedge clk);
    ps2_data = 1'b1;
    sbq.push_back({2'b00, 8'h0A});
    chk("t5_pushpop_count", 32'(count_o), 32'd8);
    chk("t5_pushpop_noovf", 32'(n_ovf - snap_ovf), 32'd0);
    for (int i = 0; i < DEPTH; i++) read_check($sformatf("t5_drain%0d", i));
    chk("t5_drained_empty", 32'(empty_o), 32'd1);

    // Reset mid-frame, then recovery and rx_en gating
    good(8'h11); good(8'h22); good(8'h33);
    chk("t6_count3", 32'(count_o), 32'd3);
    send_bits(frame(8'h44, 1'b0, 1'b1), 0, 4);
    snap_par = n_par; snap_frm = n_frm; snap_ovf = n_ovf;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_empty", 32'(empty_o), 32'd1);
    chk("t6_rst_count", 32'(count_o), 32'd0);
    sbq.delete();
    ext_f = 1'b0; brk_f = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_no_pulses", 32'((n_par - snap_par) + (n_frm - snap_frm) + (n_ovf - snap_ovf)), 32'd0);
    good(8'h5A);
    read_check("t6_fresh_5a");
    snap_par = n_par; snap_frm = n_frm;
    rx_en = 1'b0;
    send_bits(frame(8'h33, 1'b0, 1'b1), 0, 11);
    rx_en = 1'b1;
    repeat (50) @(negedge clk);
    chk("t6_rxen_ignored", 32'(count_o), 32'd0);
    chk("t6_rxen_noerr", 32'((n_par - snap_par) + (n_frm - snap_frm)), 32'd0);
    f = frame(8'h66, 1'b0, 1'b1);
    send_bits(f, 0, 3);
    rx_en = 1'b0;
    send_bits(f, 3, 11);
    rx_en = 1'b1;
    model_byte(8'h66);
    read_check("t6_rxen_midframe_66");

    chk("pulse_width", 32'(n_wide), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
